// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI memory request sequencer.
package spi_mem_ctrl_pkg;

  // Sequencer states; the buffer-hit path skips straight from StIdle to StResp.
  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StResp
  } state_e;

  // Which CPU-side port owns the transaction in flight.
  typedef enum logic {
    GntIf,
    GntD
  } grant_e;

  localparam int unsigned TimeoutDefault = 1023;

  // Byte returned to the requester when the watchdog aborts a transfer.
  localparam logic [7:0] TimeoutData = 8'hFF;

endpackage

// File: rtl/spi_mem_fbuf.sv
// One-entry fetch buffer: tag/data/valid with a combinational hit compare,
// refill on completed fetches and write-through update on matching data writes.
module spi_mem_fbuf
  import spi_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter bit          ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [7:0]        hit_data,
  input  logic              fill,
  input  logic              wr,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [7:0]        upd_data
);

  logic              valid;
  logic [ADDR_W-1:0] tag;
  logic [7:0]        data;

  // Lookup is purely combinational so the sequencer can branch in the request cycle.
  always_comb begin
    hit      = ENABLE && valid && (tag == lookup_addr);
    hit_data = data;
  end

  // Refill on a completed fetch; a data write to the cached address keeps it coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= ENABLE;
      tag   <= upd_addr;
      data  <= upd_data;
    end else if (wr && valid && (tag == upd_addr)) begin
      data  <= upd_data;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Memory-request sequencer in front of the SPI RAM engine. Arbitrates fetch and
// data ports (data wins), runs one engine transaction at a time, serves repeat
// fetches from a one-entry buffer and aborts hung transfers with a watchdog.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter bit          FBUF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [7:0]        if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [7:0]        d_wdata,
  output logic              d_ack,
  output logic [7:0]        d_rdata,
  output logic              spi_start,
  output logic              spi_write,
  output logic [ADDR_W-1:0] spi_address,
  output logic [7:0]        spi_wdata,
  input  logic              spi_done,
  input  logic [7:0]        spi_rdata,
  output logic              timeout_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  state_e         state;
  grant_e         gnt;
  logic [7:0]     resp;
  logic [WdW-1:0] wd_cnt;

  logic       d_go;
  logic       if_go;
  logic       wd_expired;
  logic       fb_hit;
  logic [7:0] fb_data;
  logic       fb_fill;
  logic       fb_wr;

  // Request qualification, watchdog expiry and buffer update strobes.
  always_comb begin
    // A req still high in the cycle its ack is out is the old request, not a new one.
    d_go       = d_req && !d_ack;
    if_go      = if_req && !if_ack;
    wd_expired = (wd_cnt >= WdLast);
    // Completion beats expiry, so these only fire on successful transfers.
    fb_fill    = (state == StWaitHigh) && spi_done && (gnt == GntIf);
    fb_wr      = (state == StWaitHigh) && spi_done && (gnt == GntD) && spi_write;
  end

  spi_mem_fbuf #(
    .ADDR_W (ADDR_W),
    .ENABLE (FBUF_EN)
  ) u_fbuf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (if_addr),
    .hit         (fb_hit),
    .hit_data    (fb_data),
    .fill        (fb_fill),
    .wr          (fb_wr),
    .upd_addr    (spi_address),
    .upd_data    (fb_wr ? spi_wdata : spi_rdata)
  );

  // Sequencer FSM with registered engine-side and CPU-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      gnt         <= GntIf;
      resp        <= '0;
      wd_cnt      <= '0;
      if_ack      <= 1'b0;
      if_rdata    <= '0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      spi_start   <= 1'b0;
      spi_write   <= 1'b0;
      spi_address <= '0;
      spi_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      unique case (state)
        StIdle: begin
          wd_cnt <= '0;
          if (d_go) begin
            gnt         <= GntD;
            spi_write   <= d_we;
            spi_address <= d_addr;
            spi_wdata   <= d_wdata;
            spi_start   <= 1'b1;
            state       <= StIssue;
          end else if (if_go) begin
            gnt <= GntIf;
            if (fb_hit) begin
              resp  <= fb_data;
              state <= StResp;
            end else begin
              spi_write   <= 1'b0;
              spi_address <= if_addr;
              spi_wdata   <= '0;
              spi_start   <= 1'b1;
              state       <= StIssue;
            end
          end
        end
        StIssue: begin
          state <= StWaitLow;
        end
        StWaitLow: begin
          if (!spi_done) begin
            wd_cnt <= wd_cnt + WdW'(1);
            state  <= StWaitHigh;
          end else if (wd_expired) begin
            resp        <= TimeoutData;
            timeout_err <= 1'b1;
            state       <= StResp;
          end else begin
            wd_cnt <= wd_cnt + WdW'(1);
          end
        end
        StWaitHigh: begin
          if (spi_done) begin
            resp  <= spi_rdata;
            state <= StResp;
          end else if (wd_expired) begin
            resp        <= TimeoutData;
            timeout_err <= 1'b1;
            state       <= StResp;
          end else begin
            wd_cnt <= wd_cnt + WdW'(1);
          end
        end
        StResp: begin
          if (gnt == GntD) begin
            d_ack <= 1'b1;
            if (!spi_write) begin
              d_rdata <= resp;
            end
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= resp;
          end
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
